// File: rtl/scan_test_ctrl_if.sv
// Pattern-pair channel between a pattern source and the scan-test sequencer.
// The source drives stimulus/expected vectors under a valid/ready handshake.
interface scan_test_ctrl_if #(
   parameter int CHAIN_LEN = 7
);
   logic                 pat_valid;
   logic                 pat_ready;
   logic [CHAIN_LEN-1:0] pat_stim;
   logic [CHAIN_LEN-1:0] pat_exp;

   modport master (output pat_valid, output pat_stim, output pat_exp, input pat_ready);
   modport slave  (input pat_valid, input pat_stim, input pat_exp, output pat_ready);
endinterface

// File: rtl/scan_test_ctrl.sv
// Scan-test sequencer: loads stimulus, pulses capture, unloads and compares responses.
// Optional macro SCAN_FAIL_LOG_EN adds first-failure index/response capture outputs.
module scan_test_ctrl #(
   parameter int CHAIN_LEN = 7,
   parameter int CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 start,
   input  logic [CNT_W-1:0]     num_pat,
   scan_test_ctrl_if.slave      pat,
   output logic                 scan_mode,
   output logic                 scan_in,
   input  logic                 scan_out,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     fail_cnt,
   output logic                 pass
`ifdef SCAN_FAIL_LOG_EN
   ,
   output logic [CNT_W-1:0]     first_fail_idx,
   output logic [CHAIN_LEN-1:0] first_fail_resp
`endif
);

   localparam int BIT_W = (CHAIN_LEN > 2) ? $clog2(CHAIN_LEN) : 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      CAPTURE,
      UNLOAD,
      DONE
   } state_t;

   state_t               state;
   state_t               stateNext;
   logic [CHAIN_LEN-1:0] stimSr;
   logic [CHAIN_LEN-1:0] respSr;
   logic [CHAIN_LEN-1:0] expNxt;
   logic [CHAIN_LEN-1:0] expCur;
   logic [CHAIN_LEN-1:0] respNext;
   logic [BIT_W-1:0]     bitCnt;
   logic [CNT_W-1:0]     patRem;
   logic                 haveResp;
   logic                 lastBit;
   logic                 cmpEn;
   logic                 mismatch;
`ifdef SCAN_FAIL_LOG_EN
   logic [CNT_W-1:0]     cmpIdx;
`endif

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // The response register sees the bit sampled on the current edge, so the
   // comparison on the last shift cycle uses the fully assembled vector.
   assign respNext = {respSr[CHAIN_LEN-2:0], scan_out};
   assign lastBit  = (bitCnt == BIT_W'(CHAIN_LEN - 1));
   assign cmpEn    = lastBit && (((state == SHIFT) && haveResp) || (state == UNLOAD));
   assign mismatch = cmpEn && (respNext != expCur);

   always_ff @(posedge clk) begin
      if (clr) state <= IDLE;
      else     state <= stateNext;
   end

   always_comb begin
      stateNext     = state;
      pat.pat_ready = 1'b0;
      scan_mode     = 1'b0;
      scan_in       = 1'b0;
      busy          = 1'b1;
      done          = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) stateNext = (num_pat == '0) ? DONE : LOAD;
         end
         LOAD: begin
            pat.pat_ready = 1'b1;
            if (pat.pat_valid) stateNext = SHIFT;
         end
         SHIFT: begin
            scan_mode = 1'b1;
            scan_in   = stimSr[CHAIN_LEN-1];
            if (lastBit) stateNext = CAPTURE;
         end
         CAPTURE: stateNext = (patRem != '0) ? LOAD : UNLOAD;
         UNLOAD: begin
            scan_mode = 1'b1;
            if (lastBit) stateNext = DONE;
         end
         DONE: begin
            done      = 1'b1;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         stimSr   <= '0;
         respSr   <= '0;
         expNxt   <= '0;
         expCur   <= '0;
         bitCnt   <= '0;
         patRem   <= '0;
         haveResp <= 1'b0;
         fail_cnt <= '0;
         pass     <= 1'b0;
`ifdef SCAN_FAIL_LOG_EN
         cmpIdx          <= '0;
         first_fail_idx  <= '0;
         first_fail_resp <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               bitCnt <= '0;
               if (start) begin
                  patRem   <= num_pat;
                  haveResp <= 1'b0;
                  fail_cnt <= '0;
                  pass     <= (num_pat == '0);
`ifdef SCAN_FAIL_LOG_EN
                  cmpIdx          <= '0;
                  first_fail_idx  <= '0;
                  first_fail_resp <= '0;
`endif
               end
            end
            LOAD: begin
               bitCnt <= '0;
               if (pat.pat_valid) begin
                  stimSr <= pat.pat_stim;
                  expNxt <= pat.pat_exp;
               end
            end
            SHIFT: begin
               stimSr <= {stimSr[CHAIN_LEN-2:0], 1'b0};
               respSr <= respNext;
               bitCnt <= bitCnt + BIT_W'(1);
               if (lastBit) begin
                  bitCnt <= '0;
                  expCur <= expNxt;
                  patRem <= patRem - CNT_W'(1);
               end
            end
            CAPTURE: begin
               haveResp <= 1'b1;
               bitCnt   <= '0;
            end
            UNLOAD: begin
               respSr <= respNext;
               bitCnt <= bitCnt + BIT_W'(1);
               if (lastBit) begin
                  bitCnt <= '0;
                  pass   <= (fail_cnt == '0) && !mismatch;
               end
            end
            default: bitCnt <= '0;
         endcase

         if (mismatch) fail_cnt <= satInc(fail_cnt);
`ifdef SCAN_FAIL_LOG_EN
         if (cmpEn) cmpIdx <= cmpIdx + CNT_W'(1);
         // A zero fail count at a mismatch marks the first failure of the run.
         if (mismatch && (fail_cnt == '0)) begin
            first_fail_idx  <= cmpIdx;
            first_fail_resp <= respNext;
         end
`endif
      end
   end

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Scoreboard bench for scan_test_ctrl with a behavioural 7-flop scan-wrapped block.
module tb_scan_test_ctrl;
   localparam int CL = 7;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          clr;
   logic          start;
   logic [CW-1:0] num_pat;
   logic          scan_mode, scan_in, scan_out, busy, done, pass;
   logic [CW-1:0] fail_cnt;
`ifdef SCAN_FAIL_LOG_EN
   logic [CW-1:0] first_fail_idx;
   logic [CL-1:0] first_fail_resp;
`endif

   scan_test_ctrl_if #(.CHAIN_LEN(CL)) pif ();

   scan_test_ctrl #(.CHAIN_LEN(CL), .CNT_W(CW)) dut (
      .clk(clk), .clr(clr), .start(start), .num_pat(num_pat), .pat(pif.slave),
      .scan_mode(scan_mode), .scan_in(scan_in), .scan_out(scan_out),
      .busy(busy), .done(done), .fail_cnt(fail_cnt), .pass(pass)
`ifdef SCAN_FAIL_LOG_EN
      , .first_fail_idx(first_fail_idx), .first_fail_resp(first_fail_resp)
`endif
   );

   always #5 clk = ~clk;

   // Scan-wrapped block: chain[3:0] are input flops (hold on capture),
   // chain[6:4] are output flops loading the block function.
   logic [CL-1:0] chain = '0;
   function automatic logic [2:0] blockFn(input logic [3:0] x);
      return {x[3] ^ x[2], x[1] & x[0], x[3] | x[0]};
   endfunction
   always @(posedge clk) begin
      if (scan_mode) chain <= {chain[CL-2:0], scan_in};
      else           chain <= {blockFn(chain[3:0]), chain[3:0]};
   end
   assign scan_out = chain[CL-1];

   typedef struct {
      logic [CW-1:0] fc;
      logic          ps;
      int            lat;
      logic [CW-1:0] ffi;
      logic [CL-1:0] ffr;
   } res_t;

   res_t          resQ[$];
   logic          scanQ[$];
   int            cyc = 0;
   int            startCyc = 0;
   int            checks = 0;
   int            errors = 0;
   logic [CL-1:0] stimA [4];
   logic [CL-1:0] expA [4];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Monitor: pops expected scan_in bits and run results as the DUT presents them.
   always @(negedge clk) begin
      res_t r;
      if (scan_mode) begin
         if (scanQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scan_mode_unexpected: got 1 expected 0 (cycle %0d)", cyc);
         end else begin
            chk("scan_in", scan_in, scanQ.pop_front());
         end
      end
      if (pif.pat_ready) chk("scan_mode_in_load", scan_mode, 0);
      if (done) begin
         if (resQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_unexpected: got 1 expected 0 (cycle %0d)", cyc);
         end else begin
            r = resQ.pop_front();
            chk("fail_cnt", fail_cnt, r.fc);
            chk("pass", pass, r.ps);
            chk("latency", cyc - startCyc, r.lat);
            chk("busy_in_done", busy, 1);
`ifdef SCAN_FAIL_LOG_EN
            chk("first_fail_idx", first_fail_idx, r.ffi);
            chk("first_fail_resp", first_fail_resp, r.ffr);
`endif
         end
      end
   end

   task automatic sendPat(input logic [CL-1:0] s, input logic [CL-1:0] e,
                          input int stall, input bit last);
      int t = 0;
      if (stall > 0) begin
         pif.pat_valid = 1'b0;
         while (!pif.pat_ready && t < 500) begin @(negedge clk); t++; end
         repeat (stall) @(negedge clk);
      end
      pif.pat_valid = 1'b1;
      pif.pat_stim  = s;
      pif.pat_exp   = e;
      t = 0;
      while (!pif.pat_ready && t < 500) begin @(negedge clk); t++; end
      chk("pat_ready_wait", pif.pat_ready, 1);
      for (int b = CL - 1; b >= 0; b--) scanQ.push_back(s[b]);
      if (last) repeat (CL) scanQ.push_back(1'b0);
      @(negedge clk);
      pif.pat_valid = 1'b0;
   endtask

   task automatic waitIdle();
      int t = 0;
      while (busy && t < 2000) begin @(negedge clk); t++; end
      chk("idle_wait", busy, 0);
   endtask

   task automatic runTest(input int n, input logic [CW-1:0] fc, input logic ps, input int lat,
                          input logic [CW-1:0] ffi, input logic [CL-1:0] ffr,
                          input int stallIdx, input int stallLen);
      res_t r;
      r.fc = fc; r.ps = ps; r.lat = lat; r.ffi = ffi; r.ffr = ffr;
      resQ.push_back(r);
      num_pat  = CW'(n);
      start    = 1'b1;
      startCyc = cyc;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < n; i++)
         sendPat(stimA[i], expA[i], (i == stallIdx) ? stallLen : 0, i == n - 1);
      waitIdle();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      clr = 1'b1; start = 1'b0; num_pat = '0;
      pif.pat_valid = 1'b0; pif.pat_stim = '0; pif.pat_exp = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_scan_mode", scan_mode, 0);
      chk("rst_scan_in", scan_in, 0);
      chk("rst_pat_ready", pif.pat_ready, 0);
      chk("rst_fail_cnt", fail_cnt, 0);
      chk("rst_pass", pass, 0);
      clr = 1'b0;
      @(negedge clk);

      // Single good pattern: scan_in 1,0,1,0,0,1,1 then seven zeros.
      stimA[0] = 7'b1010011; expA[0] = 7'b0110011;
      runTest(1, 0, 1, 17, 0, '0, -1, 0);

      // Three patterns, expected vector of pattern 1 deliberately wrong.
      stimA[1] = 7'b0101100; expA[1] = 7'b0011101;
      stimA[2] = 7'b1111111; expA[2] = 7'b0111111;
      runTest(3, 1, 0, 35, 1, 7'b0011100, -1, 0);

      // Empty run.
      runTest(0, 0, 1, 1, 0, '0, -1, 0);

      // Same three patterns with a five-cycle source stall before pattern 1.
      runTest(3, 1, 0, 40, 1, 7'b0011100, 1, 5);
      repeat (4) @(negedge clk);
      chk("hold_fail_cnt", fail_cnt, 1);
      chk("hold_pass", pass, 0);

      // Abort on the third shift cycle.
      num_pat = 8'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      sendPat(stimA[0], expA[0], 0, 1'b0);
      repeat (2) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_scan_mode", scan_mode, 0);
      chk("abort_fail_cnt", fail_cnt, 0);
      chk("abort_done", done, 0);
      scanQ.delete();
      repeat (3) @(negedge clk);

      // Fresh two-pattern run after the abort.
      stimA[1] = 7'b1111111; expA[1] = 7'b0111111;
      runTest(2, 0, 1, 26, 0, '0, -1, 0);

      // Start pulses while busy and in the done cycle must be ignored.
      begin
         res_t r;
         int t = 0;
         r.fc = 0; r.ps = 1; r.lat = 17; r.ffi = 0; r.ffr = '0;
         resQ.push_back(r);
         num_pat = 8'd1; start = 1'b1; startCyc = cyc;
         @(negedge clk);
         start = 1'b0;
         sendPat(stimA[0], expA[0], 0, 1'b1);
         num_pat = 8'd3; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         while (!done && t < 100) begin @(negedge clk); t++; end
         chk("done_seen", done, 1);
         num_pat = 8'd2; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk("done_start_ignored", busy, 0);
         repeat (30) @(negedge clk);
         chk("stay_idle", busy, 0);
      end

      chk("pending_results", resQ.size(), 0);
      chk("pending_scan_bits", scanQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
